// File: rtl/dmix_pkg.sv
// -----------------------------------------------------------------------------
// dmix_pkg
//   Shared constants and helpers for the dmix output path.
//   - RATE_48K / RATE_96K / RATE_192K : rate select encodings (3 is reserved)
//   - FRAME_BITS / SLOT_BITS          : I2S frame geometry (two 32-bit slots)
//   - clk_per_bit(rate)               : system clocks per serial bit
//   - rate_map(rate)                  : folds the reserved code onto 48k
//   - i2s_timing_t                    : bit-timing view shared by the timing
//                                       generator and the transmitter
// -----------------------------------------------------------------------------
package dmix_pkg;

   localparam logic [1:0] RATE_48K  = 2'd0;
   localparam logic [1:0] RATE_96K  = 2'd1;
   localparam logic [1:0] RATE_192K = 2'd2;

   localparam int FRAME_BITS = 64;
   localparam int SLOT_BITS  = 32;

   // Bit-timing view published by dmix_i2s_timing.
   //   b      : bit index within the frame (0..63); b[5] selects the channel
   //   load   : last clock of the frame, the frame-reload strobe
   //   bck_hi : second half of the current bit (BCK high phase)
   typedef struct packed {
      logic [5:0] b;
      logic       load;
      logic       bck_hi;
   } i2s_timing_t;

   function automatic logic [1:0] rate_map(input logic [1:0] rate);
      rate_map = (rate == RATE_96K || rate == RATE_192K) ? rate : RATE_48K;
   endfunction

   function automatic logic [5:0] clk_per_bit(input logic [1:0] rate);
      case (rate)
         RATE_96K:  clk_per_bit = 6'd16;
         RATE_192K: clk_per_bit = 6'd8;
         default:   clk_per_bit = 6'd32;
      endcase
   endfunction

endpackage

// File: rtl/dmix_i2s_timing.sv
// -----------------------------------------------------------------------------
// dmix_i2s_timing
//   Bit/frame timing for the dmix I2S transmitter. Divides clk983040 down to
//   the serial bit rate with a clock-within-bit counter d (0..N-1) and a bit
//   counter b (0..63). The rate is latched once per frame so a frame never
//   changes speed part-way through.
//
// Ports
//   clk983040 in  98.304 MHz system clock
//   rst_n     in  synchronous active-low reset
//   rate      in  requested rate code (applied at the next frame boundary)
//   tstate    out bit index, frame-reload strobe and BCK phase
// -----------------------------------------------------------------------------
module dmix_i2s_timing
   import dmix_pkg::*;
(
   input  logic        clk983040,
   input  logic        rst_n,
   input  logic [1:0]  rate,
   output i2s_timing_t tstate
);

   logic [4:0] d_q;
   logic [5:0] b_q;
   logic [1:0] rate_q;
   logic [5:0] n_bit;
   logic       bit_end;
   logic       load;

   assign n_bit   = clk_per_bit(rate_q);
   assign bit_end = ({1'b0, d_q} == (n_bit - 6'd1));
   assign load    = bit_end && (b_q == 6'(FRAME_BITS - 1));

   // While reset is held the rate keeps tracking the input, so the first
   // frame after release already runs at the requested speed.
   always_ff @(posedge clk983040) begin
      if (!rst_n) begin
         d_q    <= '0;
         b_q    <= '0;
         rate_q <= rate_map(rate);
      end else begin
         if (bit_end) begin
            d_q <= '0;
            b_q <= b_q + 6'd1;   // 63 wraps to 0 naturally
         end else begin
            d_q <= d_q + 5'd1;
         end
         if (load) begin
            rate_q <= rate_map(rate);
         end
      end
   end

   always_comb begin
      tstate        = '0;
      tstate.b      = b_q;
      tstate.load   = load;
      // BCK falls at the start of each bit and rises half-way through it.
      tstate.bck_hi = ({1'b0, d_q} >= {1'b0, n_bit[5:1]});
   end

endmodule

// File: rtl/dmix_i2s_tx.sv
// -----------------------------------------------------------------------------
// dmix_i2s_tx
//   I2S transmitter for the dmix output path. Stereo sample pairs arrive over
//   a valid/ready handshake into a one-deep holding register and are
//   serialised MSB-first as 64-bit I2S frames (two 32-bit slots, one-BCK
//   data delay) at 48/96/192 kHz, all derived from clk983040.
//
// Ports
//   clk983040  in  98.304 MHz system clock
//   rst_n      in  synchronous active-low reset
//   rate_i     in  rate select: 0=48k, 1=96k, 2=192k, 3=treated as 48k
//   in_l_i     in  left sample  (SAMPLE_W bits, MSB-first on the wire)
//   in_r_i     in  right sample (SAMPLE_W bits)
//   in_valid_i in  sample pair valid
//   in_ready_o out holding register empty
//   bck_o      out I2S bit clock
//   lrck_o     out word select (0 = left, 1 = right)
//   sd_o       out serial data
//   frame_o    out one-cycle pulse after each frame reload
//   underrun_o out one-cycle pulse after a reload that found no sample
// -----------------------------------------------------------------------------
module dmix_i2s_tx
   import dmix_pkg::*;
#(
   parameter int SAMPLE_W = 24
)
(
   input  logic                clk983040,
   input  logic                rst_n,
   input  logic [1:0]          rate_i,
   input  logic [SAMPLE_W-1:0] in_l_i,
   input  logic [SAMPLE_W-1:0] in_r_i,
   input  logic                in_valid_i,
   output logic                in_ready_o,
   output logic                bck_o,
   output logic                lrck_o,
   output logic                sd_o,
   output logic                frame_o,
   output logic                underrun_o
);

   // Left-justify a sample inside its 32-bit slot with the MSB at slot
   // position 1; position 0 and the tail stay zero.
   localparam int SLOT_SHIFT = SLOT_BITS - 1 - SAMPLE_W;

   i2s_timing_t         tstate;

   logic                hold_full;
   logic [SAMPLE_W-1:0] hold_l;
   logic [SAMPLE_W-1:0] hold_r;
   logic [SAMPLE_W-1:0] sh_l;
   logic [SAMPLE_W-1:0] sh_r;

   logic                xfer;
   logic                starved;
   logic [4:0]          slot_pos;
   logic [31:0]         slot_l;
   logic [31:0]         slot_r;
   logic                sd_next;

   dmix_i2s_timing u_timing (
      .clk983040 (clk983040),
      .rst_n     (rst_n),
      .rate      (rate_i),
      .tstate    (tstate)
   );

   // Handshake: a pair transfers on any rising edge where in_valid_i and
   // in_ready_o are both high. in_ready_o depends only on the holding
   // register, never on in_valid_i, so a producer may hold valid high
   // indefinitely; data must stay stable while valid is high and ready low.
   assign in_ready_o = !hold_full;

   always_comb begin
      xfer     = in_valid_i && in_ready_o;
      // Reload with nothing held and nothing arriving on this very edge.
      starved  = tstate.load && !hold_full && !xfer;
      slot_pos = tstate.b[4:0];
      slot_l   = 32'(sh_l) << SLOT_SHIFT;
      slot_r   = 32'(sh_r) << SLOT_SHIFT;
      // Slot position p maps to slot-word bit 31-p, which is ~p for 5 bits.
      sd_next  = tstate.b[5] ? slot_r[~slot_pos] : slot_l[~slot_pos];
   end

   // Holding register and shift words.
   always_ff @(posedge clk983040) begin
      if (!rst_n) begin
         hold_full <= 1'b0;
         hold_l    <= '0;
         hold_r    <= '0;
         sh_l      <= '0;
         sh_r      <= '0;
      end else if (tstate.load) begin
         if (hold_full) begin
            sh_l      <= hold_l;
            sh_r      <= hold_r;
            hold_full <= 1'b0;
         end else if (xfer) begin
            // Pair arriving on the reload edge goes straight to the shifter.
            sh_l <= in_l_i;
            sh_r <= in_r_i;
         end else begin
            sh_l <= '0;
            sh_r <= '0;
         end
      end else if (xfer) begin
         hold_l    <= in_l_i;
         hold_r    <= in_r_i;
         hold_full <= 1'b1;
      end
   end

   // Pins are registered copies of the previous cycle's timing state.
   always_ff @(posedge clk983040) begin
      if (!rst_n) begin
         bck_o      <= 1'b0;
         lrck_o     <= 1'b0;
         sd_o       <= 1'b0;
         frame_o    <= 1'b0;
         underrun_o <= 1'b0;
      end else begin
         bck_o      <= tstate.bck_hi;
         lrck_o     <= tstate.b[5];
         sd_o       <= sd_next;
         frame_o    <= tstate.load;
         underrun_o <= starved;
      end
   end

endmodule
